// File: rtl/rggen_atomic_register_common_if.sv
// Bus-side request/response bundle between the register-block bus adapter
// and one register core.
interface rggen_atomic_register_common_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic                     write;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     active;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, write, address, write_data, strobe,
    input  active, ready, status, read_data
  );

  modport slave (
    input  valid, write, address, write_data, strobe,
    output active, ready, status, read_data
  );
endinterface

// File: rtl/rggen_atomic_register_common.sv
// Register core: splits a register into bus-width word slots and drives the
// bit-field request. Wide registers may use atomic mode, where lower-word
// writes are collected in a shadow buffer and committed with the last word,
// and a word-0 read snapshots the whole register for coherent upper reads.
module rggen_atomic_register_common #(
  parameter bit                    READABLE       = 1'b1,
  parameter bit                    WRITABLE       = 1'b1,
  parameter int                    ADDRESS_WIDTH  = 8,
  parameter int                    OFFSET_ADDRESS = 0,
  parameter int                    BUS_WIDTH      = 32,
  parameter int                    DATA_WIDTH     = BUS_WIDTH,
  parameter logic [DATA_WIDTH-1:0] VALID_BITS     = '1,
  parameter int                    REGISTER_INDEX = 0,
  parameter bit                    ATOMIC         = 1'b1
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  rggen_atomic_register_common_if.slave bus,
  input  logic                  i_additional_match,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic                  o_bf_valid,
  output logic [DATA_WIDTH-1:0] o_bf_read_mask,
  output logic [DATA_WIDTH-1:0] o_bf_write_mask,
  output logic [DATA_WIDTH-1:0] o_bf_write_data,
  input  logic [DATA_WIDTH-1:0] i_bf_read_data,
  input  logic [DATA_WIDTH-1:0] i_bf_value
);
  localparam int WORDS     = DATA_WIDTH / BUS_WIDTH;
  localparam int BYTES     = BUS_WIDTH / 8;
  localparam int LSB       = $clog2(BYTES);
  localparam int WA_W      = ADDRESS_WIDTH - LSB;
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam bit ATOMIC_EN = ATOMIC && (WORDS > 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HELD} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [WORDS-1:0]        match;
  logic [IDX_W-1:0]        idx;
  logic                    access_ok;
  logic                    req;
  logic [BUS_WIDTH-1:0]    bmask;
  logic [DATA_WIDTH-1:0]   masked_rd;
  logic [DATA_WIDTH-1:0]   shadow_data;
  logic [DATA_WIDTH-1:0]   shadow_mask;
  logic [DATA_WIDTH-1:0]   snapshot;
  logic [BUS_WIDTH-1:0]    read_data;

  // Word-aligned address of word k of this register.
  function automatic logic [WA_W-1:0] word_address(input int k);
    return WA_W'((OFFSET_ADDRESS + (DATA_WIDTH / 8) * REGISTER_INDEX + BYTES * k) >> LSB);
  endfunction

  // Byte-offset bits never take part in word decode.
  if (LSB > 0) begin : g_lsb
    logic unused_address;
    assign unused_address = ^bus.address[LSB-1:0];
  end

  assign access_ok = bus.write ? WRITABLE : READABLE;
  assign masked_rd = i_bf_read_data & VALID_BITS;

  // Per-word decode, qualified by access direction and external match.
  always_comb begin
    match = '0;
    for (int k = 0; k < WORDS; k++) begin
      match[k] = (bus.address[ADDRESS_WIDTH-1:LSB] == word_address(k)) &&
                 i_additional_match && access_ok;
    end
  end

  // Index of the matched word (at most one word can match).
  always_comb begin
    idx = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (match[k]) idx = IDX_W'(k);
    end
  end

  // Byte strobes expanded to a bit mask for one bus word.
  always_comb begin
    bmask = '0;
    for (int b = 0; b < BYTES; b++) bmask[8*b +: 8] = {8{bus.strobe[b]}};
  end

  assign req           = bus.valid && (|match);
  assign bus.active    = |match;
  assign bus.ready     = req;
  assign bus.status    = 2'b00;
  assign bus.read_data = read_data;
  assign o_bf_valid    = req;
  assign o_value       = i_bf_value & VALID_BITS;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: writes collect or commit, word-0 reads hold a snapshot,
  // any other read of this register ends collection or holding.
  always_comb begin
    state_next = state;
    if (ATOMIC_EN && req) begin
      if (bus.write)                   state_next = (idx == LAST) ? IDLE : COLLECT;
      else if (idx == '0)              state_next = HELD;
      else if (state == HELD)          state_next = (idx == LAST) ? IDLE : HELD;
      else                             state_next = IDLE;
    end
  end

  // Bit-field request and bus read data for the current access.
  always_comb begin
    o_bf_read_mask  = '0;
    o_bf_write_mask = '0;
    o_bf_write_data = {WORDS{bus.write_data}};
    read_data       = '0;
    if (req) begin
      if (bus.write) begin
        if (!ATOMIC_EN) begin
          o_bf_write_mask[idx*BUS_WIDTH +: BUS_WIDTH] = bmask;
        end else if (idx == LAST) begin
          o_bf_write_mask = shadow_mask;
          o_bf_write_mask[(WORDS-1)*BUS_WIDTH +: BUS_WIDTH] = bmask;
          o_bf_write_data = shadow_data;
          o_bf_write_data[(WORDS-1)*BUS_WIDTH +: BUS_WIDTH] = bus.write_data;
        end
      end else begin
        if (ATOMIC_EN && (idx == '0)) begin
          o_bf_read_mask = '1;
          read_data      = masked_rd[BUS_WIDTH-1:0];
        end else if (ATOMIC_EN && (state == HELD)) begin
          read_data = snapshot[idx*BUS_WIDTH +: BUS_WIDTH];
        end else begin
          o_bf_read_mask[idx*BUS_WIDTH +: BUS_WIDTH] = '1;
          read_data = masked_rd[idx*BUS_WIDTH +: BUS_WIDTH];
        end
      end
    end
  end

  // Shadow buffer and read snapshot updates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_data <= '0;
      shadow_mask <= '0;
      snapshot    <= '0;
    end else if (ATOMIC_EN && req) begin
      if (bus.write && (idx != LAST)) begin
        shadow_data[idx*BUS_WIDTH +: BUS_WIDTH] <=
          (shadow_data[idx*BUS_WIDTH +: BUS_WIDTH] & ~bmask) | (bus.write_data & bmask);
        shadow_mask[idx*BUS_WIDTH +: BUS_WIDTH] <=
          shadow_mask[idx*BUS_WIDTH +: BUS_WIDTH] | bmask;
      end else begin
        shadow_data <= '0;
        shadow_mask <= '0;
        if (!bus.write && (idx == '0)) snapshot <= masked_rd;
      end
    end
  end
endmodule

// File: tb/tb_rggen_atomic_register_common.sv
// Bench for rggen_atomic_register_common: three instances (atomic, plain,
// atomic with a partial valid-bit mask) share one stimulus stream.
module tb_rggen_atomic_register_common;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, write, addl;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [63:0] bf_rd, bf_val;
  int          checks = 0;
  int          errors = 0;

  logic        bfv_a, bfv_b, bfv_c;
  logic [63:0] rm_a, wm_a, wd_a, val_a;
  logic [63:0] rm_b, wm_b, wd_b, val_b;
  logic [63:0] rm_c, wm_c, wd_c, val_c;

  always #5 clk = ~clk;

  rggen_atomic_register_common_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_a ();
  rggen_atomic_register_common_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_b ();
  rggen_atomic_register_common_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_c ();

  assign bus_a.valid = valid; assign bus_a.write = write; assign bus_a.address = addr;
  assign bus_a.write_data = wdata; assign bus_a.strobe = strb;
  assign bus_b.valid = valid; assign bus_b.write = write; assign bus_b.address = addr;
  assign bus_b.write_data = wdata; assign bus_b.strobe = strb;
  assign bus_c.valid = valid; assign bus_c.write = write; assign bus_c.address = addr;
  assign bus_c.write_data = wdata; assign bus_c.strobe = strb;

  rggen_atomic_register_common #(
    .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(16), .BUS_WIDTH(32), .DATA_WIDTH(64), .ATOMIC(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a), .i_additional_match(addl), .o_value(val_a),
    .o_bf_valid(bfv_a), .o_bf_read_mask(rm_a), .o_bf_write_mask(wm_a),
    .o_bf_write_data(wd_a), .i_bf_read_data(bf_rd), .i_bf_value(bf_val)
  );

  rggen_atomic_register_common #(
    .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(16), .BUS_WIDTH(32), .DATA_WIDTH(64), .ATOMIC(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b), .i_additional_match(addl), .o_value(val_b),
    .o_bf_valid(bfv_b), .o_bf_read_mask(rm_b), .o_bf_write_mask(wm_b),
    .o_bf_write_data(wd_b), .i_bf_read_data(bf_rd), .i_bf_value(bf_val)
  );

  rggen_atomic_register_common #(
    .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(16), .BUS_WIDTH(32), .DATA_WIDTH(64),
    .VALID_BITS(64'h0000_00FF_0000_FFFF), .ATOMIC(1'b1)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .bus(bus_c), .i_additional_match(addl), .o_value(val_c),
    .o_bf_valid(bfv_c), .o_bf_read_mask(rm_c), .o_bf_write_mask(wm_c),
    .o_bf_write_data(wd_c), .i_bf_read_data(bf_rd), .i_bf_value(bf_val)
  );

  function automatic logic [31:0] expand(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Present one request and wait until mid-cycle so outputs have settled.
  task automatic drive(input logic v, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    valid = v; write = w; addr = a; wdata = d; strb = s;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; valid = 1'b0; addl = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_pulse();
    bf_rd = 64'h1111_2222_3333_4444;
    drive(1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus_a.ready); end
    checks++; if (bfv_a !== 1'b0) begin errors++; $display("FAIL reset_bf_valid got %b exp 0", bfv_a); end
    checks++; if (bus_a.active !== 1'b1) begin errors++; $display("FAIL reset_active got %b exp 1", bus_a.active); end
    checks++; if (rm_a !== 64'h0) begin errors++; $display("FAIL reset_rmask_idle got %h exp 0", rm_a); end
    checks++; if (bus_a.status !== 2'b00) begin errors++; $display("FAIL reset_status got %b exp 00", bus_a.status); end
    // A fresh core reads word 1 directly, not from a snapshot.
    drive(1'b1, 1'b0, 8'h14, 32'h0, 4'h0);
    checks++; if (rm_a !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL reset_upper_rmask got %h exp ffffffff00000000", rm_a); end
    checks++; if (bus_a.read_data !== 32'h1111_2222) begin errors++; $display("FAIL reset_upper_rdata got %h exp 11112222", bus_a.read_data); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_atomic_write();
    reset_pulse();
    drive(1'b1, 1'b1, 8'h10, 32'hAAAA_5555, 4'hF);
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL aw_ready got %b exp 1", bus_a.ready); end
    checks++; if (wm_a !== 64'h0) begin errors++; $display("FAIL aw_low_wmask got %h exp 0", wm_a); end
    step();
    drive(1'b1, 1'b1, 8'h14, 32'h1234_5678, 4'hF);
    checks++; if (wm_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL aw_commit_wmask got %h exp ffffffffffffffff", wm_a); end
    checks++; if (wd_a !== 64'h1234_5678_AAAA_5555) begin errors++; $display("FAIL aw_commit_wdata got %h exp 12345678aaaa5555", wd_a); end
    checks++; if (bfv_a !== 1'b1) begin errors++; $display("FAIL aw_commit_valid got %b exp 1", bfv_a); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_snapshot_read();
    reset_pulse();
    bf_rd = 64'hDEAD_BEEF_CAFE_F00D;
    drive(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    checks++; if (bus_a.read_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL snap_w0_rdata got %h exp cafef00d", bus_a.read_data); end
    checks++; if (rm_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL snap_w0_rmask got %h exp all ones", rm_a); end
    step();
    bf_rd = 64'h0123_4567_89AB_CDEF;
    drive(1'b1, 1'b0, 8'h14, 32'h0, 4'h0);
    checks++; if (bus_a.read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL snap_w1_rdata got %h exp deadbeef", bus_a.read_data); end
    checks++; if (rm_a !== 64'h0) begin errors++; $display("FAIL snap_w1_rmask got %h exp 0", rm_a); end
    step();
    drive(1'b1, 1'b0, 8'h14, 32'h0, 4'h0);
    checks++; if (bus_a.read_data !== 32'h0123_4567) begin errors++; $display("FAIL snap_after_rdata got %h exp 01234567", bus_a.read_data); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_collect_discard();
    reset_pulse();
    drive(1'b1, 1'b1, 8'h10, 32'h5A5A_5A5A, 4'hF);
    step();
    drive(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    step();
    drive(1'b1, 1'b1, 8'h14, 32'h0000_0001, 4'hF);
    checks++; if (wm_a !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL discard_wmask got %h exp ffffffff00000000", wm_a); end
    checks++; if (wd_a[63:32] !== 32'h1) begin errors++; $display("FAIL discard_wdata got %h exp 1", wd_a[63:32]); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_reset_mid_collect();
    reset_pulse();
    drive(1'b1, 1'b1, 8'h10, 32'hFFFF_0000, 4'hF);
    step();
    valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'h14, 32'h0000_00AB, 4'hF);
    checks++; if (wm_a !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL rstcol_wmask got %h exp ffffffff00000000", wm_a); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_non_atomic();
    reset_pulse();
    drive(1'b1, 1'b1, 8'h10, 32'h1234_ABCD, 4'h3);
    checks++; if (wm_b !== 64'h0000_0000_0000_FFFF) begin errors++; $display("FAIL plain_w0_wmask got %h exp 000000000000ffff", wm_b); end
    checks++; if (wd_b !== 64'h1234_ABCD_1234_ABCD) begin errors++; $display("FAIL plain_w0_wdata got %h exp 1234abcd1234abcd", wd_b); end
    step();
    drive(1'b1, 1'b1, 8'h14, 32'h1234_ABCD, 4'hC);
    checks++; if (wm_b !== 64'hFFFF_0000_0000_0000) begin errors++; $display("FAIL plain_w1_wmask got %h exp ffff000000000000", wm_b); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_valid_bits();
    reset_pulse();
    bf_rd = '1; bf_val = '1;
    drive(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    checks++; if (bus_c.read_data !== 32'h0000_FFFF) begin errors++; $display("FAIL vb_w0_rdata got %h exp 0000ffff", bus_c.read_data); end
    checks++; if (val_c !== 64'h0000_00FF_0000_FFFF) begin errors++; $display("FAIL vb_value got %h exp 000000ff0000ffff", val_c); end
    step();
    drive(1'b1, 1'b0, 8'h14, 32'h0, 4'h0);
    checks++; if (bus_c.read_data !== 32'h0000_00FF) begin errors++; $display("FAIL vb_w1_rdata got %h exp 000000ff", bus_c.read_data); end
    step();
    valid = 1'b0;
  endtask

  task automatic test_decode();
    reset_pulse();
    drive(1'b1, 1'b1, 8'h10, 32'h1122_3344, 4'hF);
    step();
    drive(1'b1, 1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF);
    checks++; if (bus_a.active !== 1'b0) begin errors++; $display("FAIL dec_miss_active got %b exp 0", bus_a.active); end
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL dec_miss_ready got %b exp 0", bus_a.ready); end
    step();
    addl = 1'b0;
    drive(1'b1, 1'b1, 8'h14, 32'hFFFF_FFFF, 4'hF);
    checks++; if (bus_a.active !== 1'b0) begin errors++; $display("FAIL dec_addl_active got %b exp 0", bus_a.active); end
    checks++; if (wm_a !== 64'h0) begin errors++; $display("FAIL dec_addl_wmask got %h exp 0", wm_a); end
    step();
    addl = 1'b1;
    drive(1'b1, 1'b1, 8'h14, 32'h5566_7788, 4'hF);
    checks++; if (wd_a !== 64'h5566_7788_1122_3344) begin errors++; $display("FAIL dec_keep_wdata got %h exp 5566778811223344", wd_a); end
    step();
    valid = 1'b0;
  endtask

  // Random back-to-back traffic on the atomic and plain cores against a
  // word-level reference model.
  task automatic test_random_back_to_back();
    logic [31:0] m_sd, m_sm, bm, d;
    logic [63:0] m_snap, rd, e_wm, e_rm, e_wd, e_wm_b, e_rm_b;
    logic [31:0] e_rd, e_rd_b;
    logic [7:0]  a;
    logic        m_held, v, w, hit, e_rdy, chk_rd, chk_wd, r;
    logic [3:0]  s;
    int          k;
    reset_pulse();
    m_sd = '0; m_sm = '0; m_snap = '0; m_held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) != 0);
      w = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0, 1:    a = 8'h10;
        2, 3:    a = 8'h14;
        4:       a = 8'h18;
        default: a = 8'($urandom);
      endcase
      d  = $urandom;
      s  = 4'($urandom);
      rd = {$urandom, $urandom};
      r  = ($urandom_range(0, 29) == 0);
      addl  = ($urandom_range(0, 15) != 0);
      bf_rd = rd;
      rst   = r;
      drive(v, w, a, d, s);

      hit   = addl && ((a >> 2) == 8'd4 || (a >> 2) == 8'd5);
      k     = ((a >> 2) == 8'd5) ? 1 : 0;
      bm    = expand(s);
      e_rdy = v && hit;
      e_wm = '0; e_rm = '0; e_wd = '0; e_rd = '0; e_wm_b = '0; e_rm_b = '0; e_rd_b = '0;
      chk_rd = 1'b0; chk_wd = 1'b0;
      if (e_rdy) begin
        if (w) begin
          e_wm_b = {32'h0, bm} << (32 * k);
          m_held = 1'b0;
          if (k == 0) begin
            m_sd = (m_sd & ~bm) | (d & bm);
            m_sm = m_sm | bm;
          end else begin
            e_wm = {bm, m_sm};
            e_wd = {d, m_sd};
            chk_wd = 1'b1;
            m_sd = '0; m_sm = '0;
          end
        end else begin
          e_rm_b = 64'hFFFF_FFFF << (32 * k);
          e_rd_b = (k == 1) ? rd[63:32] : rd[31:0];
          chk_rd = 1'b1;
          m_sd = '0; m_sm = '0;
          if (k == 0) begin
            e_rm = '1; e_rd = rd[31:0]; m_snap = rd; m_held = 1'b1;
          end else if (m_held) begin
            e_rd = m_snap[63:32]; m_held = 1'b0;
          end else begin
            e_rm = 64'hFFFF_FFFF_0000_0000; e_rd = rd[63:32];
          end
        end
      end
      if (r) begin
        m_sd = '0; m_sm = '0; m_snap = '0; m_held = 1'b0;
      end

      checks++; if (bus_a.ready !== e_rdy) begin errors++; $display("FAIL rnd_ready it=%0d got %b exp %b", i, bus_a.ready, e_rdy); end
      checks++; if (wm_a !== e_wm) begin errors++; $display("FAIL rnd_wmask it=%0d got %h exp %h", i, wm_a, e_wm); end
      checks++; if (rm_a !== e_rm) begin errors++; $display("FAIL rnd_rmask it=%0d got %h exp %h", i, rm_a, e_rm); end
      checks++; if (wm_b !== e_wm_b) begin errors++; $display("FAIL rnd_plain_wmask it=%0d got %h exp %h", i, wm_b, e_wm_b); end
      checks++; if (rm_b !== e_rm_b) begin errors++; $display("FAIL rnd_plain_rmask it=%0d got %h exp %h", i, rm_b, e_rm_b); end
      if (chk_rd) begin
        checks++; if (bus_a.read_data !== e_rd) begin errors++; $display("FAIL rnd_rdata it=%0d got %h exp %h", i, bus_a.read_data, e_rd); end
        checks++; if (bus_b.read_data !== e_rd_b) begin errors++; $display("FAIL rnd_plain_rdata it=%0d got %h exp %h", i, bus_b.read_data, e_rd_b); end
      end
      if (chk_wd) begin
        checks++; if (wd_a !== e_wd) begin errors++; $display("FAIL rnd_wdata it=%0d got %h exp %h", i, wd_a, e_wd); end
      end
      step();
    end
    rst = 1'b0; valid = 1'b0; addl = 1'b1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; write = 1'b0; addl = 1'b1; addr = '0;
    wdata = '0; strb = '0; bf_rd = '0; bf_val = '0;
    step();
    test_reset();
    test_atomic_write();
    test_snapshot_read();
    test_collect_discard();
    test_reset_mid_collect();
    test_non_atomic();
    test_valid_bits();
    test_decode();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
